// File: rtl/lsu_mem_adapter_if.sv
// Bundle of the request, RAM and response channels of the load/store adapter.
interface lsu_mem_adapter_if;
  // Execute-stage request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  // Data RAM port
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  // Response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Environment side: issues requests, models the RAM, consumes responses
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output mem_rdata, resp_ready,
    input  req_ready, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  resp_valid, resp_rdata, resp_err
  );

  // Adapter side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  mem_rdata, resp_ready,
    output req_ready, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter: turns one sized request into a word-aligned RAM access
// held for LATENCY cycles, then returns extended load data or an error.
module lsu_mem_adapter #(
  parameter int unsigned LATENCY = 1
) (
  input logic              clock,
  input logic              reset,
  lsu_mem_adapter_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lat_write;
  logic [1:0]         lat_off;
  logic [1:0]         lat_size;
  logic               lat_unsigned;

  logic               req_legal;
  logic [DATA_W-1:0]  fmt_wdata;
  logic [3:0]         fmt_mask;
  logic [DATA_W-1:0]  rd_shifted;
  logic [DATA_W-1:0]  rd_ext;

  // Legality check and store lane formatting of the incoming request
  always_comb begin
    req_legal = 1'b0;
    fmt_wdata = bus.req_wdata;
    fmt_mask  = 4'b1111;
    case (bus.req_size)
      2'd0: begin
        req_legal = 1'b1;
        fmt_wdata = {4{bus.req_wdata[7:0]}};
        fmt_mask  = 4'b0001 << bus.req_addr[1:0];
      end
      2'd1: begin
        req_legal = ~bus.req_addr[0];
        fmt_wdata = {2{bus.req_wdata[15:0]}};
        fmt_mask  = 4'b0011 << bus.req_addr[1:0];
      end
      2'd2: begin
        req_legal = (bus.req_addr[1:0] == 2'b00);
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
  end

  // Byte-lane extraction and sign/zero extension of the RAM read word
  always_comb begin
    rd_shifted = bus.mem_rdata >> {lat_off, 3'b000};
    rd_ext     = rd_shifted;
    case (lat_size)
      2'd0: rd_ext = lat_unsigned ? {24'd0, rd_shifted[7:0]}
                                  : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: rd_ext = lat_unsigned ? {16'd0, rd_shifted[15:0]}
                                  : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  // Request/access/response sequencing with registered outputs; mem_wen is
  // raised on entry to the final access cycle so a store writes exactly once
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_write      <= 1'b0;
      lat_off        <= 2'd0;
      lat_size       <= 2'd0;
      lat_unsigned   <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.mem_valid  <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wmask  <= 4'b0000;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write     <= bus.req_write;
            lat_off       <= bus.req_addr[1:0];
            lat_size      <= bus.req_size;
            lat_unsigned  <= bus.req_unsigned;
            bus.req_ready <= 1'b0;
            if (req_legal) begin
              state         <= ACCESS;
              cnt           <= CNT_W'(LATENCY - 1);
              bus.mem_valid <= 1'b1;
              bus.mem_wen   <= bus.req_write && (LATENCY == 1);
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata <= fmt_wdata;
              bus.mem_wmask <= fmt_mask;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state          <= RESP;
            bus.mem_valid  <= 1'b0;
            bus.mem_wen    <= 1'b0;
            bus.mem_wmask  <= 4'b0000;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= lat_write ? '0 : rd_ext;
          end else begin
            cnt         <= cnt - CNT_W'(1);
            bus.mem_wen <= lat_write && (cnt == CNT_W'(1));
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter: one instance with LATENCY=1 and
// one with LATENCY=4 share the stimulus; the instance under test is selected.
module tb_lsu_mem_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_ready;
  logic        rd_mode;
  logic [31:0] rd_fixed;
  logic        sel4;
  int unsigned cyc = 0;

  int checks = 0;
  int errors = 0;

  lsu_mem_adapter_if if1();
  lsu_mem_adapter_if if4();

  lsu_mem_adapter #(.LATENCY(1)) u_dut1 (.clock(clk), .reset(reset), .bus(if1.slave));
  lsu_mem_adapter #(.LATENCY(4)) u_dut4 (.clock(clk), .reset(reset), .bus(if4.slave));

  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents vary with address and with the cycle, so sampling on the
  // wrong access cycle yields a different word
  function automatic logic [31:0] rd_fn(input logic [31:0] a, input int unsigned c);
    return (a * 32'h9E3779B1) ^ (c * 32'h01000193) ^ 32'hC001D00D;
  endfunction

  assign if1.req_valid    = req_valid;
  assign if1.req_write    = req_write;
  assign if1.req_addr     = req_addr;
  assign if1.req_wdata    = req_wdata;
  assign if1.req_size     = req_size;
  assign if1.req_unsigned = req_unsigned;
  assign if1.resp_ready   = resp_ready;
  assign if1.mem_rdata    = rd_mode ? rd_fixed : rd_fn(if1.mem_addr, cyc);
  assign if4.req_valid    = req_valid;
  assign if4.req_write    = req_write;
  assign if4.req_addr     = req_addr;
  assign if4.req_wdata    = req_wdata;
  assign if4.req_size     = req_size;
  assign if4.req_unsigned = req_unsigned;
  assign if4.resp_ready   = resp_ready;
  assign if4.mem_rdata    = rd_mode ? rd_fixed : rd_fn(if4.mem_addr, cyc);

  logic        o_req_ready, o_mem_valid, o_mem_wen, o_resp_valid, o_resp_err;
  logic [31:0] o_mem_addr, o_mem_wdata, o_resp_rdata;
  logic [3:0]  o_mem_wmask;

  always_comb begin
    o_req_ready  = sel4 ? if4.req_ready  : if1.req_ready;
    o_mem_valid  = sel4 ? if4.mem_valid  : if1.mem_valid;
    o_mem_wen    = sel4 ? if4.mem_wen    : if1.mem_wen;
    o_mem_addr   = sel4 ? if4.mem_addr   : if1.mem_addr;
    o_mem_wdata  = sel4 ? if4.mem_wdata  : if1.mem_wdata;
    o_mem_wmask  = sel4 ? if4.mem_wmask  : if1.mem_wmask;
    o_resp_valid = sel4 ? if4.resp_valid : if1.resp_valid;
    o_resp_rdata = sel4 ? if4.resp_rdata : if1.resp_rdata;
    o_resp_err   = sel4 ? if4.resp_err   : if1.resp_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load result: pick the addressed lanes, then extend
  function automatic logic [31:0] model_load(input logic [31:0] word, input int b,
                                             input logic [1:0] sz, input bit un);
    logic [31:0] v;
    v = word >> (8 * b);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!un && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (!un && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One full transaction on the selected instance, checked against the model
  task automatic run_txn(input bit s4, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit un,
                         input int hold, output logic [31:0] got_rdata);
    int          lat, b, n, nmv, nwen, k;
    bit          legal, wen_ok;
    logic [31:0] exp_addr, exp_wd, exp_rd, word;
    logic [3:0]  exp_mask;
    lat      = s4 ? 4 : 1;
    b        = int'(a[1:0]);
    legal    = (sz == 2'd0) || (sz == 2'd1 && (b % 2) == 0) || (sz == 2'd2 && b == 0);
    exp_addr = a & 32'hFFFF_FFFC;
    exp_mask = (sz == 2'd2) ? 4'hF : 4'(((sz == 2'd0) ? 1 : 3) << b);
    exp_wd   = (sz == 2'd0) ? wd[7:0] * 32'h0101_0101 :
               (sz == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;

    sel4 = s4;
    @(negedge clk);
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    req_size = sz; req_unsigned = un; resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = int'(cyc);
    n = 0; nmv = 0; nwen = 0; wen_ok = 1'b1;
    while (!o_resp_valid && n < 40) begin
      if (o_mem_valid) begin
        nmv++;
        check("mem_addr", o_mem_addr, exp_addr);
        check("mem_wdata", o_mem_wdata, exp_wd);
        check("mem_wmask", 32'(o_mem_wmask), 32'(exp_mask));
        if (o_mem_wen && n != lat - 1) wen_ok = 1'b0;
      end else if (o_mem_wen) begin
        wen_ok = 1'b0;
      end
      if (o_mem_wen) nwen++;
      @(posedge clk); #1;
      n++;
    end
    word   = rd_mode ? rd_fixed : rd_fn(exp_addr, 32'(k + lat - 1));
    exp_rd = (!legal || w) ? 32'd0 : model_load(word, b, sz, un);
    check("resp_latency", 32'(n), 32'(legal ? lat : 0));
    check("mem_valid_cycles", 32'(nmv), 32'(legal ? lat : 0));
    check("mem_wen_count", 32'(nwen), 32'((legal && w) ? 1 : 0));
    check("mem_wen_last_cycle", 32'(wen_ok), 32'd1);
    check("mem_idle_in_resp", {o_mem_valid, o_mem_wen, o_mem_wmask}, 32'd0);
    check("resp_err", 32'(o_resp_err), 32'(!legal));
    check("resp_rdata", o_resp_rdata, exp_rd);
    got_rdata = o_resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_resp_valid", 32'(o_resp_valid), 32'd1);
      check("hold_resp_rdata", o_resp_rdata, exp_rd);
      check("hold_resp_err", 32'(o_resp_err), 32'(!legal));
      check("hold_req_ready", 32'(o_req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("resp_dropped", 32'(o_resp_valid), 32'd0);
    check("req_ready_after", 32'(o_req_ready), 32'd1);
    n = 0;
    while (!(if1.req_ready && if4.req_ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("both_idle_timeout", 32'(n < 40), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          nwen;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
    rd_mode = 1'b1; rd_fixed = 32'd0; sel4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel4 = (s == 1);
      #1;
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_mem", {o_mem_valid, o_mem_wen, o_mem_wmask}, 32'd0);
      check("rst_mem_addr", o_mem_addr, 32'd0);
      check("rst_resp", {o_resp_valid, o_resp_err}, 32'd0);
      check("rst_resp_rdata", o_resp_rdata, 32'd0);
    end

    // Directed cases
    run_txn(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, r);
    run_txn(1'b0, 1'b1, 32'h8000_0003, 32'h1234_565A, 2'd0, 1'b0, 0, r);
    rd_fixed = 32'h8001_1234;
    run_txn(1'b0, 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 0, r);
    check("half_signed", r, 32'hFFFF_8001);
    run_txn(1'b0, 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 0, r);
    check("half_unsigned", r, 32'h0000_8001);
    run_txn(1'b0, 1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 0, r);
    run_txn(1'b0, 1'b0, 32'h8000_0008, 32'h0, 2'd3, 1'b0, 0, r);
    run_txn(1'b0, 1'b1, 32'h8000_0005, 32'h0, 2'd1, 1'b0, 0, r);
    rd_fixed = 32'h0000_7F00;
    run_txn(1'b1, 1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 3, r);
    check("byte_lat4", r, 32'h0000_007F);

    // Reset during the second access cycle of a LATENCY=4 store
    sel4 = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = 32'hCAFE_F00D; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nwen = o_mem_wen ? 1 : 0;
    @(posedge clk); #1;
    check("abort_in_access", 32'(o_mem_valid), 32'd1);
    nwen += o_mem_wen ? 1 : 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_req_ready", 32'(o_req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_resp", 32'(o_resp_valid), 32'd0);
      nwen += o_mem_wen ? 1 : 0;
      @(posedge clk); #1;
    end
    check("abort_no_wen", 32'(nwen), 32'd0);

    // Reset on the last access cycle: the write still appears that cycle
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("last_cycle_wen", 32'(o_mem_wen), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("late_abort_no_resp", 32'(o_resp_valid), 32'd0);
      check("late_abort_idle", 32'(o_req_ready), 32'd1);
      @(posedge clk); #1;
    end

    // Randomized transactions against the reference model
    rd_mode = 1'b0;
    for (int i = 0; i < 80; i++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'h8000_0000 | ($urandom & 32'h0000_0FFF), $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
